// File: rtl/cmp_irq_unit_if.sv
// Wishbone classic slave bundle for cmp_irq_unit.
// Signal names follow the Wishbone slave port naming of the block.
interface cmp_irq_unit_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/cmp_irq_unit.sv
// Compare/match interrupt unit with Wishbone register file.
// Optional missed-match counter: define CMP_IRQ_MISSCNT_EN.
module cmp_irq_unit #(
  parameter int MISS_W = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [31:0]   count_i,
  cmp_irq_unit_if.slave wbs,
  output logic          irq_o
);

  logic [2:0]  ctrl_q;
  logic [31:0] cmp_q;
  logic [31:0] per_q;
  logic [31:0] rdat_q;
  logic [31:0] rd_mux;
  logic [31:0] status;
  logic        pend_q;
  logic        m_q;
  logic        ack_q;

  logic        acc;
  logic        wr;
  logic        rd;
  logic        m;
  logic        hit;
  logic        a_ctrl;
  logic        a_cmp;
  logic        a_st;
  logic        a_per;
  logic        st_wr;
  logic        pend_clr;
  logic [3:0]  sel;
  logic [31:0] wd;

  logic        unused_adr;

  function automatic logic [31:0] bmerge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  assign acc    = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
  assign wr     = acc & wbs.wbs_we_i;
  assign rd     = acc & ~wbs.wbs_we_i;
  assign sel    = wbs.wbs_sel_i;
  assign wd     = wbs.wbs_dat_i;
  assign a_ctrl = wbs.wbs_adr_i[3:2] == 2'd0;
  assign a_cmp  = wbs.wbs_adr_i[3:2] == 2'd1;
  assign a_st   = wbs.wbs_adr_i[3:2] == 2'd2;
  assign a_per  = wbs.wbs_adr_i[3:2] == 2'd3;

  assign unused_adr = ^{wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0]};

  assign st_wr    = wr & a_st;
  assign pend_clr = st_wr & sel[0] & wd[0];

  // Edge-detected match so a stalled count fires once.
  assign m   = ctrl_q[0] & (count_i == cmp_q);
  assign hit = m & ~m_q;

  assign irq_o         = pend_q & ctrl_q[2];
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = ack_q ? rdat_q : 32'd0;

`ifdef CMP_IRQ_MISSCNT_EN
  logic [MISS_W-1:0] miss_q;

  // Missed-match counter; software clear beats a same-cycle increment.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      miss_q <= '0;
    end else if (st_wr & sel[1]) begin
      miss_q <= '0;
    end else if (hit & pend_q & ~(&miss_q)) begin
      miss_q <= miss_q + MISS_W'(1);
    end
  end

  // STATUS view with the counter field.
  always_comb begin
    status              = '0;
    status[0]           = pend_q;
    status[8 +: MISS_W] = miss_q;
  end
`else
  logic [MISS_W-1:0] unused_miss;
  assign unused_miss = '0;

  // STATUS view without the counter field.
  always_comb begin
    status    = '0;
    status[0] = pend_q;
  end
`endif

  // Read mux over the four registers.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      a_ctrl:  rd_mux = {29'd0, ctrl_q};
      a_cmp:   rd_mux = cmp_q;
      a_st:    rd_mux = status;
      a_per:   rd_mux = per_q;
      default: rd_mux = '0;
    endcase
  end

  // Bus handshake and read-data capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q  <= acc;
      rdat_q <= rd ? rd_mux : 32'd0;
    end
  end

  // Control, period and compare registers; software CMP write beats reload.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_q <= '0;
      per_q  <= '0;
      cmp_q  <= '0;
    end else begin
      if (wr & a_ctrl & sel[0]) ctrl_q <= wd[2:0];
      if (wr & a_per) per_q <= bmerge(per_q, wd, sel);
      if (wr & a_cmp) begin
        cmp_q <= bmerge(cmp_q, wd, sel);
      end else if (hit & ctrl_q[1]) begin
        cmp_q <= cmp_q + per_q;
      end
    end
  end

  // Match history and pending flag; a hit beats a software clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      m_q    <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      m_q <= m;
      if (hit) begin
        pend_q <= 1'b1;
      end else if (pend_clr) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmp_irq_unit.sv
// Scoreboard bench for cmp_irq_unit.
// Reference model tracks register state from the register rules.
module tb_cmp_irq_unit;
  localparam int MW   = 8;
  localparam int MAXM = (1 << MW) - 1;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] count_i = '0;
  logic        irq;

  cmp_irq_unit_if bus();

  cmp_irq_unit #(.MISS_W(MW)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .count_i  (count_i),
    .wbs      (bus),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] r_cmp  = '0;
  logic [31:0] r_per  = '0;
  logic [2:0]  r_ctrl = '0;
  bit          r_pend = 0;
  int          r_miss = 0;
  bit          r_last = 0;
  bit          r_ack  = 0;
  bit          r_ackrd = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] reg_val(input logic [1:0] a);
    logic [31:0] st;
    st = {31'd0, r_pend};
`ifdef CMP_IRQ_MISSCNT_EN
    st = st | (32'(r_miss) << 8);
`endif
    case (a)
      2'd0:    return {29'd0, r_ctrl};
      2'd1:    return r_cmp;
      2'd2:    return st;
      default: return r_per;
    endcase
  endfunction

  task automatic model_step();
    bit v, w, match, hit;
    logic [1:0]  a;
    logic [31:0] d, nc;
    logic [3:0]  s;
    v = bus.wbs_cyc_i && bus.wbs_stb_i && !r_ack;
    w = v && bus.wbs_we_i;
    a = bus.wbs_adr_i[3:2];
    d = bus.wbs_dat_i;
    s = bus.wbs_sel_i;
    if (v && !bus.wbs_we_i) exp_q.push_back(reg_val(a));
    match = r_ctrl[0] && (count_i == r_cmp);
    hit   = match && !r_last;
    nc    = (hit && r_ctrl[1]) ? r_cmp + r_per : r_cmp;
    if (w && a == 2 && s[1]) r_miss = 0;
    else if (hit && r_pend && r_miss < MAXM) r_miss++;
    if (w && a == 2 && s[0] && d[0]) r_pend = 0;
    if (hit) r_pend = 1;
    if (w && a == 1) nc = merge(r_cmp, d, s);
    if (w && a == 3) r_per = merge(r_per, d, s);
    if (w && a == 0 && s[0]) r_ctrl = d[2:0];
    r_cmp   = nc;
    r_last  = match;
    r_ackrd = v && !bus.wbs_we_i;
    r_ack   = v;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      r_cmp = '0; r_per = '0; r_ctrl = '0;
      r_pend = 0; r_miss = 0; r_last = 0;
      r_ack = 0; r_ackrd = 0;
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ack", {31'd0, bus.wbs_ack_o}, {31'd0, r_ack});
    chk("irq", {31'd0, irq}, {31'd0, r_pend && r_ctrl[2]});
    if (r_ack && r_ackrd) begin
      if (exp_q.size() == 0) begin
        chk("rdata_noexp", bus.wbs_dat_o, 32'hxxxx_xxxx);
      end else begin
        chk("rdata", bus.wbs_dat_o, exp_q.pop_front());
      end
    end else begin
      chk("dat_idle", bus.wbs_dat_o, 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input bit we, input logic [31:0] adr,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rv);
    bit got;
    got = 0;
    rv  = '0;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = d; bus.wbs_sel_i = s;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        got = 1;
        rv  = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    chk("ack_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1, 32'(a) << 2, d, 4'hF, dummy);
  endtask

  task automatic rd(input int a, output logic [31:0] rv);
    xfer(0, 32'(a) << 2, 32'd0, 4'hF, rv);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    logic [31:0] sat_exp;
    bit ack_seen;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int a = 0; a < 4; a++) begin
      rd(a, rv);
      chk("reset_reg", rv, 32'd0);
    end

    wr(1, 32'h10);
    wr(0, 32'h5);
    for (int k = 0; k <= 20; k++) begin
      count_i = 32'(k);
      idle(1);
      if (k == 15) chk("oneshot_pre", {31'd0, irq}, 32'd0);
      if (k == 16) chk("oneshot_irq", {31'd0, irq}, 32'd1);
    end
    wr(2, 32'h1);
    chk("oneshot_clr", {31'd0, irq}, 32'd0);

    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
    bus.wbs_adr_i = 32'h4; bus.wbs_sel_i = 4'hF;
    #1 rst_n = 0;
    ack_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) ack_seen = 1;
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    rst_n = 1;
    chk("midread_noack", {31'd0, ack_seen}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(a, rv);
      chk("midread_reg", rv, 32'd0);
    end

    count_i = 0;
    wr(3, 32'h20);
    wr(1, 32'hFFFF_FFF0);
    wr(0, 32'h7);
    count_i = 32'hFFFF_FFF0;
    idle(2);
    rd(1, rv);
    chk("wrap_cmp", rv, 32'h10);
    wr(2, 32'h1);
    count_i = 32'hF;
    idle(1);
    chk("wrap_pre", {31'd0, irq}, 32'd0);
    count_i = 32'h10;
    idle(1);
    chk("wrap_hit2", {31'd0, irq}, 32'd1);
    rd(1, rv);
    chk("wrap_cmp2", rv, 32'h30);

    wr(0, 32'h0);
    count_i = 0;
    wr(2, 32'h101);
    wr(1, 32'h100);
    wr(0, 32'h1);
    count_i = 32'h100;
    idle(50);
    rd(2, rv);
    chk("stall_status", rv, 32'h1);

    wr(2, 32'h101);
    wr(1, 32'h200);
    for (int k = 0; k < 300; k++) begin
      count_i = 32'h201;
      idle(1);
      count_i = 32'h200;
      idle(1);
    end
    rd(2, rv);
`ifdef CMP_IRQ_MISSCNT_EN
    sat_exp = 32'hFF01;
`else
    sat_exp = 32'h1;
`endif
    chk("miss_sat", rv, sat_exp);

    count_i = 32'h201;
    idle(1);
    count_i = 32'h200;
    wr(2, 32'h1);
    rd(2, rv);
    chk("coll_pend", {31'd0, rv[0]}, 32'd1);

    wr(3, 32'h4);
    wr(0, 32'h3);
    wr(2, 32'h101);
    count_i = 32'h1FF;
    idle(1);
    count_i = 32'h200;
    wr(1, 32'h55);
    rd(1, rv);
    chk("coll_cmp", rv, 32'h55);
    rd(2, rv);
    chk("coll_cmp_pend", rv, 32'h1);

    wr(3, 32'h0);
    wr(2, 32'h101);
    count_i = 32'h54;
    idle(1);
    count_i = 32'h55;
    idle(5);
    rd(1, rv);
    chk("per0_cmp", rv, 32'h55);
    rd(2, rv);
    chk("per0_status", rv, 32'h1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] d, ad;
      case ($urandom_range(0, 3))
        0:       count_i = r_cmp;
        1:       count_i = r_cmp - 1;
        2:       count_i = r_cmp + 1;
        default: count_i = $urandom;
      endcase
      if ($urandom_range(0, 9) < 5) begin
        idle(1);
      end else begin
        ad = {$urandom_range(0, 255) << 4} | (32'($urandom_range(0, 3)) << 2);
        d  = $urandom;
        if (ad[3:2] == 2'd3) d = 32'($urandom_range(0, 7));
        xfer(1'($urandom_range(0, 1)), ad, d, 4'($urandom_range(0, 15)), rv);
      end
    end

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
